uart_tx_fifo: RTL and testbench

Byte buffer between the CPU-side write port and the UART transmitter. Accepts bytes at full clock rate and stores them in a circular FIFO. Issues them one at a time to the transmitter using its `exec`/`ready` handshake, so software never has to poll the serial line between bytes. Overflow on a full write is reported through a sticky flag.

---
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding a UART transmitter via an
// exec/ready handshake. Writes are accepted every cycle until full; dropped
// writes raise a sticky overflow flag. Status flags are registered.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  I_clk,
    input  logic                  I_reset,
    input  logic [7:0]            I_wr_data,
    input  logic                  I_wr_en,
    input  logic                  I_flush,
    input  logic                  I_clr_overflow,
    output logic                  O_full,
    output logic                  O_empty,
    output logic [DEPTH_LOG2:0]   O_count,
    output logic                  O_overflow,
    output logic [7:0]            O_tx_data,
    output logic                  O_tx_exec,
    input  logic                  I_tx_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam cnt_t CNT_ONE  = cnt_t'(1'b1);
    localparam ptr_t PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam ptr_t PTR_ONE  = ptr_t'(1'b1);

    logic [7:0] mem_r [DEPTH];
    ptr_t       wr_ptr_r;
    ptr_t       rd_ptr_r;
    cnt_t       count_r;
    logic       full_r;
    logic       empty_r;
    logic       overflow_r;
    logic [7:0] tx_data_r;
    logic       tx_exec_r;

    logic       push_s;
    logic       pop_s;
    logic       drop_s;
    cnt_t       count_nxt_s;

    // Decide push / issue / drop for this cycle and the next occupancy count.
    always_comb begin
        push_s      = 1'b0;
        pop_s       = 1'b0;
        drop_s      = I_wr_en && full_r;
        count_nxt_s = count_r;
        if (I_flush) begin
            count_nxt_s = CNT_ZERO;
        end else begin
            push_s = I_wr_en && !full_r;
            // !tx_exec_r: ready is still high the cycle exec is sampled.
            pop_s  = !empty_r && I_tx_ready && !tx_exec_r;
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointers, count, registered flags, issue register and overflow flag.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_exec_r  <= 1'b0;
        end else begin
            if (I_flush) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
            count_r   <= count_nxt_s;
            full_r    <= (count_nxt_s == CNT_FULL);
            empty_r   <= (count_nxt_s == CNT_ZERO);
            tx_exec_r <= pop_s;
            if (pop_s) begin
                tx_data_r <= mem_r[rd_ptr_r];
            end
            // A dropped write wins over a simultaneous clear.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (I_clr_overflow) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge I_clk) begin
        if (!I_reset && push_s) begin
            mem_r[wr_ptr_r] <= I_wr_data;
        end
    end

    assign O_full     = full_r;
    assign O_empty    = empty_r;
    assign O_count    = count_r;
    assign O_overflow = overflow_r;
    assign O_tx_data  = tx_data_r;
    assign O_tx_exec  = tx_exec_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small transmitter model that
// drops ready the cycle after it samples exec and stays busy a few cycles.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       flush;
    logic       clr_ov;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_exec;
    logic       tx_ready;

    logic       use_model;
    logic       man_ready;
    logic       model_ready = 1'b1;
    logic [3:0] busy = 4'd0;
    logic       prev_exec = 1'b0;
    logic       double_exec = 1'b0;
    int         exec_cnt = 0;
    logic [7:0] cap[$];

    int checks = 0;
    int errors = 0;

    assign tx_ready = use_model ? model_ready : man_ready;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .I_clk          (clk),
        .I_reset        (rst),
        .I_wr_data      (wr_data),
        .I_wr_en        (wr_en),
        .I_flush        (flush),
        .I_clr_overflow (clr_ov),
        .O_full         (full),
        .O_empty        (empty),
        .O_count        (count),
        .O_overflow     (overflow),
        .O_tx_data      (tx_data),
        .O_tx_exec      (tx_exec),
        .I_tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    // Transmitter model: capture issued bytes, go busy, flag back-to-back exec.
    always @(posedge clk) begin
        prev_exec <= tx_exec;
        if (tx_exec) begin
            cap.push_back(tx_data);
            exec_cnt    <= exec_cnt + 1;
            model_ready <= 1'b0;
            busy        <= 4'd3;
            if (prev_exec) double_exec <= 1'b1;
        end else if (!model_ready) begin
            if (busy == 4'd0) model_ready <= 1'b1;
            else busy <= busy - 4'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int base;
        int c;
        int ecnt;
        rst = 1'b1; wr_data = 8'h00; wr_en = 1'b0; flush = 1'b0; clr_ov = 1'b0;
        use_model = 1'b0; man_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_exec", 32'(tx_exec), 32'd0);
        chk("rst_data", 32'(tx_data), 32'h00);

        // Single byte latency
        wr_en = 1'b1; wr_data = 8'hA5; tick();
        wr_en = 1'b0;
        chk("lat_c1_count", 32'(count), 32'd1);
        chk("lat_c1_exec", 32'(tx_exec), 32'd0);
        tick();
        chk("lat_c2_exec", 32'(tx_exec), 32'd1);
        chk("lat_c2_data", 32'(tx_data), 32'hA5);
        chk("lat_c2_count", 32'(count), 32'd0);
        tick();
        chk("lat_c3_exec", 32'(tx_exec), 32'd0);
        chk("lat_c3_empty", 32'(empty), 32'd1);
        chk("lat_c3_hold", 32'(tx_data), 32'hA5);

        // Fill to full with the transmitter stalled
        man_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); tick();
        end
        wr_en = 1'b0;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_ovf0", 32'(overflow), 32'd0);
        wr_en = 1'b1; wr_data = 8'hFF; tick();
        wr_en = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        clr_ov = 1'b1; tick();
        chk("ovf_clr", 32'(overflow), 32'd0);
        wr_en = 1'b1; tick();
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        wr_en = 1'b0; tick();
        clr_ov = 1'b0;
        chk("ovf_clr2", 32'(overflow), 32'd0);

        // Drain and verify the 0xFF write was not stored
        base = cap.size();
        man_ready = 1'b1;
        c = 0;
        while (cap.size() < base + 16 && c < 80) begin tick(); c++; end
        tick();
        chk("drain_n", 32'(cap.size() - base), 32'd16);
        if (cap.size() >= base + 16)
            for (int i = 0; i < 16; i++) chk("drain_byte", 32'(cap[base+i]), 32'(i));
        chk("drain_empty", 32'(empty), 32'd1);

        // Simultaneous push and pop at count 3
        man_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i); tick();
        end
        chk("pp_pre_count", 32'(count), 32'd3);
        base = cap.size();
        man_ready = 1'b1; wr_en = 1'b1; wr_data = 8'h13; tick();
        wr_en = 1'b0;
        chk("pp_count", 32'(count), 32'd3);
        chk("pp_exec", 32'(tx_exec), 32'd1);
        chk("pp_data", 32'(tx_data), 32'h10);
        c = 0;
        while (cap.size() < base + 4 && c < 40) begin tick(); c++; end
        chk("pp_n", 32'(cap.size() - base), 32'd4);
        if (cap.size() >= base + 4)
            for (int i = 0; i < 4; i++) chk("pp_order", 32'(cap[base+i]), 32'h10 + 32'(i));

        // Ordering across wrap-around with the transmitter model
        tick(); tick();
        use_model = 1'b1;
        base = cap.size();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h30 + 8'(i); tick();
        end
        wr_en = 1'b0;
        repeat (20) tick();
        for (int i = 8; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 8'h30 + 8'(i); tick();
        end
        wr_en = 1'b0;
        chk("ord_no_ovf", 32'(overflow), 32'd0);
        c = 0;
        while (cap.size() < base + 20 && c < 400) begin tick(); c++; end
        chk("ord_n", 32'(cap.size() - base), 32'd20);
        if (cap.size() >= base + 20)
            for (int i = 0; i < 20; i++) chk("ord_byte", 32'(cap[base+i]), 32'h30 + 32'(i));
        repeat (10) tick();
        chk("ord_ready", 32'(model_ready), 32'd1);

        // Flush with transmitter busy and count 5
        base = cap.size();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h50 + 8'(i); tick();
        end
        wr_en = 1'b0;
        chk("fl_pre_count", 32'(count), 32'd5);
        chk("fl_pre_busy", 32'(model_ready), 32'd0);
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_empty", 32'(empty), 32'd1);
        repeat (20) tick();
        chk("fl_n", 32'(cap.size() - base), 32'd1);
        if (cap.size() > base) chk("fl_inflight", 32'(cap[base]), 32'h50);
        chk("fl_ready_back", 32'(model_ready), 32'd1);

        // Reset while count 7 and exec high
        use_model = 1'b0; man_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i); tick();
        end
        man_ready = 1'b1; wr_en = 1'b1; wr_data = 8'h67; tick();
        chk("mr_count", 32'(count), 32'd7);
        chk("mr_exec", 32'(tx_exec), 32'd1);
        wr_en = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        chk("mr_count0", 32'(count), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_full", 32'(full), 32'd0);
        chk("mr_exec0", 32'(tx_exec), 32'd0);
        chk("mr_data0", 32'(tx_data), 32'h00);
        chk("mr_ovf0", 32'(overflow), 32'd0);
        tick();
        ecnt = exec_cnt;
        repeat (10) tick();
        chk("mr_no_exec", 32'(exec_cnt - ecnt), 32'd0);
        chk("no_double_exec", 32'(double_exec), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
